// File: rtl/aspen_neuron_pkg.sv
// Shared types and saturating-arithmetic helpers for the neuron membrane datapath.
package aspen_neuron_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_LEAK  = 2'd1,
    ST_FIRE  = 2'd2
  } state_e;

  // Container wide enough for any size_mem up to 32 plus the add/sub carry.
  localparam int unsigned SAT_W = 34;
  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic wide_t sat_max(input int unsigned w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int unsigned w);
    return -sat_max(w) - wide_t'(1);
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                    input logic sub, input int unsigned w);
    wide_t s;
    s = sub ? (a - b) : (a + b);
    if (s > sat_max(w)) return sat_max(w);
    if (s < sat_min(w)) return sat_min(w);
    return s;
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Combinational signed add/subtract clamped to the W-bit two's-complement range.
module sat_add_signed
  import aspen_neuron_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic                sub_i,
  output logic signed [W-1:0] y_o
);

  always_comb begin
    y_o = W'(sat_add(SAT_W'(a_i), SAT_W'(b_i), sub_i, W));
  end

endmodule

// File: rtl/membrane_accum_fire.sv
// Membrane potential accumulator with end-of-timestep leak/threshold/fire sequence.
// Optional LEAK_EN macro builds the shift-based leak state.
module membrane_accum_fire
  import aspen_neuron_pkg::*;
#(
  parameter int unsigned size_mem  = 16,
  parameter int unsigned size_ts   = 8,
  parameter int unsigned size_leak = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic signed [size_mem-1:0] sum_in,
  input  logic signed [size_mem-1:0] threshold,
  input  logic [size_leak-1:0]       leak_shift,
  input  logic                       clear,
  output logic signed [size_mem-1:0] vmem_out,
  output logic                       spike_out,
  output logic                       spike_valid,
  output logic [size_ts-1:0]         ts_count
);

  state_e                     state_q, state_d;
  logic signed [size_mem-1:0] vmem_q, vmem_d;
  logic                       spike_q, spike_d;
  logic                       spike_valid_q, spike_valid_d;
  logic [size_ts-1:0]         ts_q, ts_d;

  logic signed [size_mem-1:0] op_b;
  logic                       op_sub;
  logic signed [size_mem-1:0] sat_y;

  // Only accept while accumulating; reset blocks the upstream immediately.
  assign in_ready = (state_q == ST_ACCUM) && !reset;

  // One saturating adder shared by the accumulate and leak paths.
  sat_add_signed #(.W(size_mem)) u_sat (
    .a_i  (vmem_q),
    .b_i  (op_b),
    .sub_i(op_sub),
    .y_o  (sat_y)
  );

`ifndef LEAK_EN
  logic unused_leak;
  assign unused_leak = ^leak_shift;
`endif

  always_comb begin
    state_d       = state_q;
    vmem_d        = vmem_q;
    spike_d       = spike_q;
    spike_valid_d = 1'b0;
    ts_d          = ts_q;
    op_b          = sum_in;
    op_sub        = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (in_valid && in_ready) begin
          vmem_d = sat_y;
          if (in_last) begin
`ifdef LEAK_EN
            state_d = ST_LEAK;
`else
            state_d = ST_FIRE;
`endif
          end
        end
      end
`ifdef LEAK_EN
      ST_LEAK: begin
        op_b    = vmem_q >>> leak_shift;
        op_sub  = 1'b1;
        vmem_d  = sat_y;
        state_d = ST_FIRE;
      end
`endif
      ST_FIRE: begin
        spike_d       = (vmem_q >= threshold);
        spike_valid_d = 1'b1;
        if (vmem_q >= threshold) vmem_d = '0;
        ts_d          = ts_q + size_ts'(1);
        state_d       = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase

    // clear wins over accumulate, leak and fire-reset.
    if (clear) vmem_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ACCUM;
      vmem_q        <= '0;
      spike_q       <= 1'b0;
      spike_valid_q <= 1'b0;
      ts_q          <= '0;
    end else begin
      state_q       <= state_d;
      vmem_q        <= vmem_d;
      spike_q       <= spike_d;
      spike_valid_q <= spike_valid_d;
      ts_q          <= ts_d;
    end
  end

  assign vmem_out    = vmem_q;
  assign spike_out   = spike_q;
  assign spike_valid = spike_valid_q;
  assign ts_count    = ts_q;

endmodule

// File: doc/membrane_accum_fire.md
# membrane_accum_fire

Downstream consumer of the skewed-offset signed adder stage. Accumulates the signed per-synapse products it produces into a membrane potential with saturation. At the end of each timestep it optionally applies a shift-based leak, compares against a threshold, and emits a one-cycle spike result. A valid/ready handshake on the input side back-pressures the adder pipeline while the end-of-timestep sequence runs.

## Interface
- size_mem, 16: width of the signed product input and of the membrane potential
- size_ts, 8: width of the timestep counter
- size_leak, 4: width of the leak shift amount

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sum_in carries a valid product
- in_ready  out  1  block accepts a beat this cycle
- in_last  in  1  beat is the last synapse of the current timestep
- sum_in  in  size_mem  signed product from the adder stage
- threshold  in  size_mem  signed firing threshold, quasi-static
- leak_shift  in  size_leak  leak amount, V -= V>>>leak_shift
- clear  in  1  synchronous zero of the membrane potential
- vmem_out  out  size_mem  current membrane potential (register)
- spike_out  out  1  spike result, qualified by spike_valid
- spike_valid  out  1  one-cycle end-of-timestep result strobe
- ts_count  out  size_ts  completed timesteps, wraps

## Operation
- Reset values: vmem_out 0, spike_out 0, spike_valid 0, ts_count 0, state ACCUM. in_ready is 0 while reset is high.
- States are ACCUM, LEAK, and FIRE. LEAK exists only with LEAK_EN.
- **ACCUM:**
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready: V <= sat(V + sum_in).
  - If in_last is set on the accepted beat, go to LEAK (or to FIRE without LEAK_EN). Otherwise stay in ACCUM.
- **LEAK:** in_ready = 0. V <= sat(V - (V >>> leak_shift)), arithmetic shift. leak_shift = 0 yields V = 0. Go to FIRE.
- **FIRE:**
  - in_ready = 0. Compare signed V >= threshold.
  - Register spike_out = compare result and spike_valid = 1.
  - If the neuron fired, V <= 0; otherwise V is held.
  - ts_count <= ts_count + 1, wrapping at 2^size_ts.
  - Go to ACCUM.
- spike_valid is cleared on the next edge, so it is high for exactly one cycle. spike_out holds its value until the next FIRE.
- **Saturation:** sums are computed in size_mem+1 bits and clamped to [-2^(size_mem-1), 2^(size_mem-1)-1].
- **clear:** forces V to 0 in any state and takes precedence over accumulate, leak, and fire-reset. It does not change the state, the spike outputs, or ts_count.
- **in_valid while not ready:** ignored. The upstream stage must hold the beat until it is accepted.
- **Reset mid-timestep:** all state returns to reset values and any partial accumulation is discarded.
- **threshold <= 0:** a spike fires at every FIRE, including for an empty-sum timestep.

## Timing
- Accumulate latency is 1: a beat accepted at edge k is reflected in vmem_out after edge k.
- Last beat accepted at edge k, with LEAK_EN:
  - LEAK during the cycle after k.
  - FIRE after edge k+1.
  - spike_valid high in the cycle after edge k+2.
  - in_ready is 0 for 2 cycles and returns to 1 in the same cycle as spike_valid.
- Without LEAK_EN, every event is one cycle earlier and in_ready is 0 for 1 cycle.
- Back-to-back single-beat timesteps are legal. Sustained throughput is 1 timestep per 3 cycles with LEAK_EN, and per 2 cycles without.

## Configuration
- LEAK_EN:
  - Defined: the LEAK state and the leak_shift port are active.
  - Undefined: the LEAK state is not built, leak_shift is ignored, and ACCUM goes directly to FIRE.

## Structure
- Shared package aspen_neuron_pkg holds:
  - the state enum (ACCUM, LEAK, FIRE);
  - the saturation bounds as functions of size_mem;
  - the sat_add helper used by both the accumulate and leak paths.
- One sub-module: sat_add_signed, a combinational (size_mem+1)-bit add with clamp, instantiated once with its operands muxed by state.

## Test plan
- **Basic accumulate:** size_mem=16, threshold=100, LEAK_EN off; beats 40, 30, 40(last) -> vmem 110, spike_out=1 and spike_valid for one cycle 2 cycles after the last accept, then vmem=0 and ts_count=1.
- **Leak:** LEAK_EN, leak_shift=2, threshold=200, beats 120, 40(last) -> vmem 160 then 120, no spike, spike_valid=1 with spike_out=0, vmem held at 120.
- **Saturation:**
  - beats 30000, 30000 -> vmem 32767.
  - beats -30000, -30000 -> vmem -32768.
- **Back-pressure:** hold in_valid high across a last beat -> in_ready low for 2 cycles (LEAK_EN), and the next beat is accepted only once in_ready returns, with no beat lost or duplicated.
- **clear vs reset:**
  - clear in the same cycle as an accepted beat of 50 -> vmem 0.
  - reset asserted while in LEAK -> all outputs at reset values the next cycle, and ts_count is unchanged from 0.
- **ts_count wrap:** size_ts=2, 5 single-beat timesteps -> ts_count sequence 1, 2, 3, 0, 1.
